// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/ready register pipeline.
package pipe_pkg;

  // Per-stage next-state control: next valid bit and data load enable.
  typedef struct packed {
    logic valid;
    logic load;
  } stage_ctl_t;

  // Bits needed to hold a count from 0 to depth inclusive.
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth + 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid bit and a data word with a local ready term.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               DATA_RST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             nxt_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  stage_ctl_t ctl;

  // An empty stage always accepts, which is what collapses bubbles.
  assign ready = !valid | nxt_ready;

  always_comb begin
    ctl       = '0;
    ctl.valid = flush ? 1'b0 : (ready ? src_valid : valid);
    ctl.load  = ready & src_valid & !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid <= 1'b0;
    else       valid <= ctl.valid;
  end

  // Data only moves when a valid word arrives, so idle stages do not toggle.
  generate
    if (DATA_RST) begin : g_data_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset)         data <= RST_VAL;
        else if (ctl.load) data <= src_data;
      end
    end else begin : g_data_nrst
      always_ff @(posedge clk) begin
        if (ctl.load) data <= src_data;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               DATA_RST = 1'b1,
  localparam int              CW       = clog2_cnt(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [CW-1:0]    count_o
);

  // Index 0 is the upstream source; index i+1 is the output of stage i.
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            rdy;
  logic                      in_xfer, out_xfer;
  logic [CW-1:0]             cnt;

  assign rdy[DEPTH]  = out_ready_i;
  assign in_ready_o  = rdy[0] & !flush_i;
  assign in_xfer     = in_valid_i & in_ready_o;
  assign vld_pipe[0] = in_xfer;
  assign dat_pipe[0] = in_data_i;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL),
        .DATA_RST(DATA_RST)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush_i),
        .src_valid(vld_pipe[i]),
        .src_data (dat_pipe[i]),
        .nxt_ready(rdy[i+1]),
        .valid    (vld_pipe[i+1]),
        .data     (dat_pipe[i+1]),
        .ready    (rdy[i])
      );
    end
  endgenerate

  assign out_valid_o = vld_pipe[DEPTH];
  assign out_data_o  = dat_pipe[DEPTH];
  assign out_xfer    = out_valid_o & out_ready_i;

  // Tracks the popcount of valid bits without an adder tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (flush_i) cnt <= '0;
    else              cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
  end

  assign count_o = cnt;

endmodule
